uart_echo_fifo: RTL

//  Buffered UART echo engine: self-contained fractional baud generator, oversampling RX,

---
 rtl/uart_echo_fifo.sv | 232 +++++++++++++++++++++++
 1 files changed

// File: rtl/uart_echo_fifo.sv
// Buffered UART echo: fractional baud tick, oversampling RX, byte FIFO, flow-controlled TX.
// Define UART_ECHO_STATS_EN to add saturating err_count / ovf_count outputs.
module uart_echo_fifo #(
  parameter int OVERSAMPLE = 3,
  parameter int ACC_W      = 10,
  parameter int INCR       = 78,
  parameter int DATA_W     = 8,
  parameter int FIFO_AW    = 4
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               rxd,
  output logic               txd,
  input  logic               tx_hold,
  output logic               rx_active,
  output logic               tx_active,
  output logic               rx_err,
  output logic               overflow,
  output logic [FIFO_AW:0]   fifo_level
`ifdef UART_ECHO_STATS_EN
  ,
  output logic [7:0]         err_count,
  output logic [7:0]         ovf_count
`endif
);

  localparam int DEPTH = 2**FIFO_AW;
  localparam int BC_W  = $clog2(DATA_W + 1);
  localparam logic [OVERSAMPLE-1:0] CNT_MAX   = '1;
  localparam logic [OVERSAMPLE-1:0] CNT_HALF  = OVERSAMPLE'(2**(OVERSAMPLE-1) - 1);
  localparam logic [OVERSAMPLE-1:0] CNT_ONE   = OVERSAMPLE'(1);
  localparam logic [BC_W-1:0]       BITS_LAST = BC_W'(DATA_W - 1);
  localparam logic [BC_W-1:0]       BIT_ONE   = BC_W'(1);
  localparam logic [FIFO_AW:0]      LVL_FULL  = (FIFO_AW+1)'(DEPTH);
  localparam logic [FIFO_AW:0]      LVL_ONE   = (FIFO_AW+1)'(1);
  localparam logic [FIFO_AW-1:0]    PTR_ONE   = FIFO_AW'(1);

  localparam logic [2:0] RX_IDLE  = 3'd0;
  localparam logic [2:0] RX_START = 3'd1;
  localparam logic [2:0] RX_DATA  = 3'd2;
  localparam logic [2:0] RX_STOP  = 3'd3;
  localparam logic [2:0] RX_BREAK = 3'd4;

  localparam logic [1:0] TX_IDLE  = 2'd0;
  localparam logic [1:0] TX_START = 2'd1;
  localparam logic [1:0] TX_DATA  = 2'd2;
  localparam logic [1:0] TX_STOP  = 2'd3;

  logic [ACC_W-1:0]      r_acc;
  logic [ACC_W:0]        w_acc_sum;
  logic                  r_tick;

  logic                  r_sync1, r_sync2, r_sync3;
  logic [2:0]            r_rx_state;
  logic [OVERSAMPLE-1:0] r_rx_cnt;
  logic [BC_W-1:0]       r_rx_bit;
  logic [DATA_W-1:0]     r_rx_shift;
  logic                  r_rx_err;
  logic                  w_rx_push;

  logic [DATA_W-1:0]     r_mem [DEPTH];
  logic [FIFO_AW-1:0]    r_wptr, r_rptr;
  logic [FIFO_AW:0]      r_level;
  logic                  r_overflow;
  logic                  w_full, w_empty, w_wr, w_pop;

  logic [1:0]            r_tx_state;
  logic [OVERSAMPLE-1:0] r_tx_cnt;
  logic [BC_W-1:0]       r_tx_bit;
  logic [DATA_W-1:0]     r_tx_shift;
  logic                  r_txd;

  assign w_acc_sum = {1'b0, r_acc} + (ACC_W+1)'(INCR);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_acc  <= '0;
      r_tick <= 1'b0;
    end else begin
      r_acc  <= w_acc_sum[ACC_W-1:0];
      r_tick <= w_acc_sum[ACC_W];
    end
  end

  assign w_rx_push = (r_rx_state == RX_STOP) && r_tick && (r_rx_cnt == CNT_MAX) && r_sync2;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sync1    <= 1'b1;
      r_sync2    <= 1'b1;
      r_sync3    <= 1'b1;
      r_rx_state <= RX_IDLE;
      r_rx_cnt   <= '0;
      r_rx_bit   <= '0;
      r_rx_shift <= '0;
      r_rx_err   <= 1'b0;
    end else begin
      r_sync1  <= rxd;
      r_sync2  <= r_sync1;
      r_sync3  <= r_sync2;
      r_rx_err <= 1'b0;
      case (r_rx_state)
        RX_IDLE: if (r_sync3 && !r_sync2) begin
          r_rx_state <= RX_START;
          r_rx_cnt   <= '0;
        end
        RX_START: if (r_tick) begin
          // Mid-start re-check rejects glitches; counter restarts so data samples land mid-bit.
          if (r_rx_cnt == CNT_HALF) begin
            r_rx_cnt   <= '0;
            r_rx_bit   <= '0;
            r_rx_state <= r_sync2 ? RX_IDLE : RX_DATA;
          end else begin
            r_rx_cnt <= r_rx_cnt + CNT_ONE;
          end
        end
        RX_DATA: if (r_tick) begin
          r_rx_cnt <= r_rx_cnt + CNT_ONE;
          if (r_rx_cnt == CNT_MAX) begin
            r_rx_shift <= {r_sync2, r_rx_shift[DATA_W-1:1]};
            r_rx_bit   <= r_rx_bit + BIT_ONE;
            if (r_rx_bit == BITS_LAST) r_rx_state <= RX_STOP;
          end
        end
        RX_STOP: if (r_tick) begin
          r_rx_cnt <= r_rx_cnt + CNT_ONE;
          if (r_rx_cnt == CNT_MAX) begin
            if (r_sync2) begin
              r_rx_state <= RX_IDLE;
            end else begin
              r_rx_err   <= 1'b1;
              r_rx_state <= RX_BREAK;
            end
          end
        end
        RX_BREAK: if (r_sync2) r_rx_state <= RX_IDLE;
        default: r_rx_state <= RX_IDLE;
      endcase
    end
  end

  assign w_full  = (r_level == LVL_FULL);
  assign w_empty = (r_level == '0);
  assign w_pop   = (r_tx_state == TX_IDLE) && !w_empty && !tx_hold;
  assign w_wr    = w_rx_push && (!w_full || w_pop);

  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wptr] <= r_rx_shift;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_level    <= '0;
      r_overflow <= 1'b0;
    end else begin
      r_overflow <= w_rx_push && w_full && !w_pop;
      if (w_wr)  r_wptr <= r_wptr + PTR_ONE;
      if (w_pop) r_rptr <= r_rptr + PTR_ONE;
      case ({w_wr, w_pop})
        2'b10:   r_level <= r_level + LVL_ONE;
        2'b01:   r_level <= r_level - LVL_ONE;
        default: r_level <= r_level;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_tx_state <= TX_IDLE;
      r_tx_cnt   <= '0;
      r_tx_bit   <= '0;
      r_tx_shift <= '0;
      r_txd      <= 1'b1;
    end else begin
      // Line is driven one clk behind the state so the start bit follows the load clk.
      r_txd <= (r_tx_state == TX_START) ? 1'b0 :
               (r_tx_state == TX_DATA)  ? r_tx_shift[0] : 1'b1;
      case (r_tx_state)
        TX_IDLE: if (w_pop) begin
          r_tx_shift <= r_mem[r_rptr];
          r_tx_cnt   <= '0;
          r_tx_bit   <= '0;
          r_tx_state <= TX_START;
        end
        TX_START: if (r_tick) begin
          r_tx_cnt <= r_tx_cnt + CNT_ONE;
          if (r_tx_cnt == CNT_MAX) r_tx_state <= TX_DATA;
        end
        TX_DATA: if (r_tick) begin
          r_tx_cnt <= r_tx_cnt + CNT_ONE;
          if (r_tx_cnt == CNT_MAX) begin
            r_tx_shift <= r_tx_shift >> 1;
            r_tx_bit   <= r_tx_bit + BIT_ONE;
            if (r_tx_bit == BITS_LAST) r_tx_state <= TX_STOP;
          end
        end
        TX_STOP: if (r_tick) begin
          r_tx_cnt <= r_tx_cnt + CNT_ONE;
          if (r_tx_cnt == CNT_MAX) r_tx_state <= TX_IDLE;
        end
        default: r_tx_state <= TX_IDLE;
      endcase
    end
  end

  assign txd        = r_txd;
  assign rx_active  = (r_rx_state != RX_IDLE);
  assign tx_active  = (r_tx_state != TX_IDLE);
  assign rx_err     = r_rx_err;
  assign overflow   = r_overflow;
  assign fifo_level = r_level;

`ifdef UART_ECHO_STATS_EN
  logic [7:0] r_err_count, r_ovf_count;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_err_count <= '0;
      r_ovf_count <= '0;
    end else begin
      if (r_rx_err && (r_err_count != 8'hFF))   r_err_count <= r_err_count + 8'd1;
      if (r_overflow && (r_ovf_count != 8'hFF)) r_ovf_count <= r_ovf_count + 8'd1;
    end
  end

  assign err_count = r_err_count;
  assign ovf_count = r_ovf_count;
`endif

endmodule
